// File: rtl/cfg_frame_loader.sv
// Serial-to-parallel configuration frame loader: assembles {LAST, ADDR, DATA} frames
// from a valid/ready bitstream and pulses one one-hot write enable per frame.
module cfg_frame_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         CK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         BIT_IN,
    input  logic                         BIT_VALID,
    output logic                         BIT_READY,
    output logic [(2**ADDR_WIDTH)-1:0]   WE,
    output logic [DATA_WIDTH-1:0]        D,
    output logic                         BUSY,
    output logic                         DONE
);

    localparam int NUM_FRAMES = 2**ADDR_WIDTH;
    localparam int FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WRITE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_BITS-2:0]   sr_q, sr_d;
    logic                    last_q, last_d;
    logic [NUM_FRAMES-1:0]   we_q, we_d;
    logic [DATA_WIDTH-1:0]   d_q, d_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [FRAME_BITS-1:0]   frame;
    logic [ADDR_WIDTH-1:0]   addr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        last_d  = last_q;
        we_d    = we_q;
        d_d     = d_q;
        // The incoming bit completes the frame combinationally so the final
        // transfer edge can load D/WE directly, without an extra cycle.
        frame   = {sr_q, BIT_IN};
        addr    = frame[DATA_WIDTH +: ADDR_WIDTH];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (BIT_VALID) begin
                    sr_d  = frame[FRAME_BITS-2:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d    = S_WRITE;
                        d_d        = frame[DATA_WIDTH-1:0];
                        we_d       = '0;
                        we_d[addr] = 1'b1;
                        last_d     = frame[FRAME_BITS-1];
                    end
                end
            end
            S_WRITE: begin
                we_d    = '0;
                cnt_d   = '0;
                state_d = last_q ? S_DONE : S_SHIFT;
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are decoded from the next state so they are registered.
        ready_d = (state_d == S_SHIFT);
        busy_d  = (state_d == S_SHIFT) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b0;
            we_q    <= '0;
            d_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
            we_q    <= we_d;
            d_q     <= d_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BIT_READY = ready_q;
    assign WE        = we_q;
    assign D         = d_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: bit-queue reference model checked every cycle,
// directed frame scenarios with literal expectations, and a downstream DFF_EN bank.
module tb_cfg_frame_loader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NF = 16;
    localparam int FB = 1 + AW + DW;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          BIT_IN = 1'b0;
    logic          BIT_VALID = 1'b0;
    logic          BIT_READY;
    logic [NF-1:0] WE;
    logic [DW-1:0] D;
    logic          BUSY;
    logic          DONE;

    int n_checks = 0;
    int n_pass   = 0;

    cfg_frame_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CK(CK), .RST(RST), .START(START), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
        .BIT_READY(BIT_READY), .WE(WE), .D(D), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Downstream DFF_EN bank fed by WE/D.
    logic [DW-1:0] bank [NF];
    initial for (int i = 0; i < NF; i++) bank[i] = '0;
    always @(posedge CK) begin
        for (int i = 0; i < NF; i++)
            if (WE[i]) bank[i] <= D;
    end

    // Reference model: collects accepted bits, decodes a frame once it has FB of them.
    bit            m_ready = 0;
    bit            m_busy  = 0;
    bit            m_done  = 0;
    bit            m_last  = 0;
    logic [NF-1:0] m_we    = '0;
    logic [DW-1:0] m_d     = '0;
    bit            m_bits[$];

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_last = 0;
            m_we = '0; m_d = '0; m_bits.delete();
        end else if (m_we != '0) begin
            m_we = '0;
            if (m_last) begin
                m_done = 1; m_busy = 0; m_ready = 0;
            end else begin
                m_ready = 1;
            end
        end else if (m_ready) begin
            if (BIT_VALID) begin
                m_bits.push_back(BIT_IN);
                if (m_bits.size() == FB) begin
                    int f;
                    f = 0;
                    foreach (m_bits[i]) f = f * 2 + int'(m_bits[i]);
                    m_last  = ((f >> (AW + DW)) & 1) != 0;
                    m_we    = NF'(1) << ((f >> DW) % NF);
                    m_d     = DW'(f % 256);
                    m_ready = 0;
                    m_bits.delete();
                end
            end
        end else if (START) begin
            m_ready = 1; m_busy = 1; m_done = 0;
        end
    end

    always @(negedge CK) begin
        check("ready", 32'(BIT_READY), 32'(m_ready));
        check("we",    32'(WE),        32'(m_we));
        check("d",     32'(D),         32'(m_d));
        check("busy",  32'(BUSY),      32'(m_busy));
        check("done",  32'(DONE),      32'(m_done));
    end

    task automatic tick();
        @(posedge CK); #1;
    endtask

    // Presents one bit after `gap` idle cycles; returns #1 after the accepting edge.
    task automatic send_bit(input logic b, input int gap);
        int cycles;
        bit acc;
        BIT_VALID = 1'b0;
        repeat (gap) tick();
        BIT_VALID = 1'b1;
        BIT_IN    = b;
        cycles    = 0;
        forever begin
            acc = BIT_READY;
            tick();
            if (acc) break;
            cycles++;
            if (cycles > 40) begin
                check("bit_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic last, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input int gap, input int nbits);
        logic [FB-1:0] f;
        f = {last, addr, data};
        for (int i = FB - 1; i >= FB - nbits; i--) send_bit(f[i], gap);
        BIT_VALID = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check("rst_we", 32'(WE), 32'h0);
        check("rst_busy_done_ready", {29'd0, BUSY, DONE, BIT_READY}, 32'h0);

        // Single frame: 1,0101,10100011
        pulse_start();
        check("start_ready", 32'(BIT_READY), 32'd1);
        send_frame(1'b1, 4'h5, 8'hA3, 0, FB);
        check("single_we", 32'(WE), 32'h0020);
        check("single_d", 32'(D), 32'hA3);
        check("bank5_before_end", 32'(bank[5]), 32'h0);
        tick();
        check("single_we_off", 32'(WE), 32'h0);
        check("single_done", {29'd0, BUSY, DONE, BIT_READY}, 32'b010);
        check("bank5_after_end", 32'(bank[5]), 32'hA3);

        // Multi-frame session
        pulse_start();
        send_frame(1'b0, 4'h0, 8'h11, 0, FB);
        check("multi0_we", 32'(WE), 32'h0001);
        check("multi0_d", 32'(D), 32'h11);
        check("multi0_gap_ready", 32'(BIT_READY), 32'd0);
        send_frame(1'b0, 4'hF, 8'h22, 0, FB);
        check("multi1_we", 32'(WE), 32'h8000);
        check("multi1_d", 32'(D), 32'h22);
        check("multi1_not_done", 32'(DONE), 32'd0);
        send_frame(1'b1, 4'h3, 8'h33, 0, FB);
        check("multi2_we", 32'(WE), 32'h0008);
        check("multi2_d", 32'(D), 32'h33);
        tick();
        check("multi_done", 32'(DONE), 32'd1);

        // Backpressure: valid 1 in every 3 cycles
        pulse_start();
        send_frame(1'b1, 4'h9, 8'h6B, 2, FB);
        check("bp_we", 32'(WE), 32'h0200);
        check("bp_d", 32'(D), 32'h6B);
        tick();

        // Reset after 7 accepted bits
        pulse_start();
        send_frame(1'b1, 4'h7, 8'hEE, 0, 7);
        RST = 1'b1;
        #1;
        check("midrst_we", 32'(WE), 32'h0);
        check("midrst_d", 32'(D), 32'h0);
        check("midrst_flags", {29'd0, BUSY, DONE, BIT_READY}, 32'h0);
        @(negedge CK);
        RST = 1'b0;
        tick();
        check("midrst_idle_ready", 32'(BIT_READY), 32'd0);
        pulse_start();
        send_frame(1'b1, 4'h2, 8'h5C, 0, FB);
        check("postrst_we", 32'(WE), 32'h0004);
        check("postrst_d", 32'(D), 32'h5C);
        tick();

        // START held through SHIFT, then restart from DONE
        START = 1'b1;
        tick();
        send_frame(1'b1, 4'hC, 8'h99, 0, FB);
        START = 1'b0;
        check("hold_we", 32'(WE), 32'h1000);
        check("hold_d", 32'(D), 32'h99);
        tick();
        check("hold_done", 32'(DONE), 32'd1);
        pulse_start();
        check("restart_done_clr", 32'(DONE), 32'd0);
        check("restart_d_kept", 32'(D), 32'h99);
        send_frame(1'b1, 4'h1, 8'h4D, 1, FB);
        check("restart_we", 32'(WE), 32'h0002);
        check("restart_d", 32'(D), 32'h4D);
        tick();

        check("bank0", 32'(bank[0]), 32'h11);
        check("bank15", 32'(bank[15]), 32'h22);
        check("bank3", 32'(bank[3]), 32'h33);
        check("bank2", 32'(bank[2]), 32'h5C);
        check("bank7_untouched", 32'(bank[7]), 32'h0);
        check("bank5_kept", 32'(bank[5]), 32'hA3);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
